// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: runs one EXMEM load/store against a
// word-addressed req/ack memory and stalls the pipeline until it retires.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);

    // Handshake: mem_req_o stays high with stable we/addr/wdata until the
    // memory answers with a single-cycle mem_ack_i (rdata valid that cycle);
    // an ack seen outside an outstanding request is ignored.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t            state;
    logic [7:0]        cnt;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              op;
    logic              aligned;
    logic [33:0]       addr_ext;

    assign op       = MemRead_i | MemWrite_i;
    assign addr_ext = {2'b00, addr_i};
    assign aligned  = (addr_ext[1:0] == 2'b00);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            data_o  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    err_q <= 1'b0;
                    if (op && aligned) begin
                        addr_q  <= addr_ext[ADDR_W+1:2];
                        wdata_q <= data_i;
                        we_q    <= MemWrite_i;
                        cnt     <= 8'd0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (mem_ack_i) begin
                        if (!we_q) begin
                            data_o <= mem_rdata_i;
                        end
                        err_q <= 1'b0;
                        state <= DONE;
                    end else if (cnt == LAST_CNT) begin
                        // A read that never completes returns zero rather than stale data.
                        if (!we_q) begin
                            data_o <= 32'd0;
                        end
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stall_o     = 1'b0;
        misalign_o  = 1'b0;
        err_o       = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'd0;
        case (state)
            IDLE: begin
                // The stall must rise in the same cycle the op appears so EXMEM holds it.
                if (rst_i && op) begin
                    stall_o    = aligned;
                    misalign_o = !aligned;
                end
            end
            REQ: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
            end
            DONE: begin
                err_o = err_q;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle data-memory access unit for the MEM stage of the 5-stage pipelined CPU. Takes the load/store presented by the EXMEM pipeline register, runs it against an external word-addressed memory with a req/ack handshake, and holds the pipeline with `stall_o` until the access completes. Read data goes to the MEMWB register's `ReadData_i`.

## Interface
Parameters:
- `ADDR_W`, 32: width of `mem_addr_o`, taken from `addr_i[ADDR_W+1:2]`, the word address.
- `TIMEOUT`, 16: maximum number of cycles spent in REQ before the access is aborted. Legal range is 2..255.

Ports (clock and reset first):
- `clk_i`  in  1  system clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-low: sampled on the rising edge of `clk_i`, asserted when 0.
- `MemRead_i`  in  1  load request from EXMEM.
- `MemWrite_i`  in  1  store request from EXMEM.
- `addr_i`  in  32  byte address from the EXMEM ALU result.
- `data_i`  in  32  store data from EXMEM.
- `data_o`  out  32  registered load data, to MEMWB.
- `stall_o`  out  1  freezes PC, IFID, IDEX and EXMEM, and inserts a bubble into MEMWB.
- `misalign_o`  out  1  one-cycle flag: the access was dropped because `addr_i[1:0]` is not 0.
- `err_o`  out  1  one-cycle flag: the access was aborted on timeout.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  1 = write, 0 = read.
- `mem_addr_o`  out  ADDR_W  word address.
- `mem_wdata_o`  out  32  write data.
- `mem_ack_i`  in  1  memory acknowledge, one cycle wide.
- `mem_rdata_i`  in  32  read data, valid in the same cycle as `mem_ack_i`.

## Operation
- The state machine has three states: IDLE, REQ and DONE. The reset state is IDLE.
- A request is `op = MemRead_i | MemWrite_i`.
- IDLE:
  - `op` with `addr_i[1:0]==0`: `stall_o`=1 combinationally in that cycle. Latch addr, data and `we = MemWrite_i` at the edge, clear the timeout counter, go to REQ.
  - `op` with `addr_i[1:0]!=0`: `misalign_o`=1 combinationally, `stall_o`=0. No memory request is issued; the operation is dropped; stay in IDLE.
  - No `op`: all flags are 0.
- REQ:
  - `stall_o`=1 and `mem_req_o`=1.
  - `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are driven from the latched registers and are stable for the whole state.
  - Counter increments by 1 each cycle.
  - On `mem_ack_i`=1: go to DONE. If the access is a read, `data_o` <= `mem_rdata_i`.
  - If the counter reaches `TIMEOUT`-1 with no ack: go to DONE with the error flag set.
- DONE:
  - Lasts exactly 1 cycle, then goes to IDLE.
  - `stall_o`=0, so the pipeline advances.
  - EXMEM request inputs are ignored in this cycle, because they still show the completed operation.
  - `err_o`=1 in this cycle if the access timed out.
- `MemRead_i` and `MemWrite_i` both high: treated as a write, and `data_o` is unchanged.
- A write never changes `data_o`. A timed-out read sets `data_o` to 0.
- `mem_ack_i` received in IDLE or DONE is ignored and has no effect.
- `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are 0 outside REQ.

## Timing
- Reset values: `data_o`=0, `stall_o`=0, `misalign_o`=0, `err_o`=0, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0. The state goes to IDLE and the counter to 0.
- Reset asserted mid-access: at the reset edge the unit enters IDLE and `mem_req_o` drops in the following cycle. A late ack is ignored.
- Let cycle 0 be the cycle in which IDLE sees `op`.
  - REQ is entered in cycle 1.
  - If the ack is sampled in cycle k (k≥1), DONE occurs in cycle k+1.
  - `stall_o` is high in cycles 0..k.
  - Best case: stall for 2 cycles, operation retires in cycle 2.
- Timeout: REQ occupies cycles 1..`TIMEOUT`, DONE with `err_o` occurs in cycle `TIMEOUT`+1, and `stall_o` is high in cycles 0..`TIMEOUT`.
- `data_o` updates at the edge that ends the ack cycle. It is valid in DONE and held until the next read completes.
- Back-to-back operations: a new `op` seen in the IDLE cycle after DONE starts immediately, so there is at most one unstalled cycle between two accesses.

## Test plan
- Load, ack in first REQ cycle: `addr_i`=0x10, `MemRead_i`=1, `mem_rdata_i`=0xCAFEF00D.
  - `mem_addr_o`=0x4 and `mem_we_o`=0.
  - `stall_o`=1 for cycles 0–1.
  - `data_o`=0xCAFEF00D in cycle 2, with `stall_o`=0.
- Store, ack after 3 cycles: `addr_i`=0x20, `data_i`=0x12345678, `MemWrite_i`=1, ack in cycle 3.
  - `mem_wdata_o`=0x12345678 and `mem_we_o`=1 held for cycles 1–3.
  - DONE in cycle 4.
  - `data_o` unchanged.
- Misaligned: `addr_i`=0x13, `MemRead_i`=1.
  - `misalign_o`=1 in cycle 0.
  - `stall_o`=0 and `mem_req_o` never asserts.
- Timeout, `TIMEOUT`=16, no ack:
  - `mem_req_o` high for exactly 16 cycles.
  - `err_o`=1 in cycle 17.
  - `data_o`=0.
  - A later stray `mem_ack_i` is ignored.
- Reset mid-access: `rst_i`=0 in cycle 2 of a read.
  - All outputs are 0 in the following cycle.
  - An ack in cycle 3 does not change `data_o`.
- Back-to-back loads to 0x0 and 0x4, each with a 1-cycle ack.
  - Two distinct `mem_addr_o` values, 0x0 and 0x1.
  - Exactly one DONE cycle between the two accesses.
  - Second `data_o` correct.
